// File: rtl/phase_seq_pkg.sv
// Shared types and defaults for the phase sequencer: FSM state encoding,
// default sizing, and the phase-count legality check.
package phase_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HOLD   = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    localparam int NPHASE_MAX_DEF = 7;
    localparam int CW_DEF         = 4;

    // Compared as int so an NPH port too narrow to exceed the maximum still lints clean.
    function automatic logic nph_legal(input int n, input int max_n);
        return (n >= 1) && (n <= max_n);
    endfunction

endpackage

// File: rtl/phase_seq_ctrl_if.sv
// Control/status bundle of the phase sequencer; master drives the controls,
// slave (the sequencer) drives the phase outputs and pulses.
interface phase_seq_ctrl_if
    import phase_seq_pkg::*;
#(
    parameter int NPHASE_MAX = NPHASE_MAX_DEF,
    parameter int CW         = CW_DEF,
    parameter int PW         = $clog2(NPHASE_MAX + 1)
);
    logic                  i_en;
    logic                  i_start;
    logic                  i_abort;
    logic                  i_mode;
    logic [CW-1:0]         i_dwell;
    logic [PW-1:0]         i_nph;
    logic [NPHASE_MAX-1:0] o_ph_oh;
    logic [PW-1:0]         o_ph_idx;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;

    modport master (
        output i_en, i_start, i_abort, i_mode, i_dwell, i_nph,
        input  o_ph_oh, o_ph_idx, o_busy, o_done, o_err
    );

    modport slave (
        input  i_en, i_start, i_abort, i_mode, i_dwell, i_nph,
        output o_ph_oh, o_ph_idx, o_busy, o_done, o_err
    );
endinterface

// File: rtl/phase_seq_ctrl_dwell_cnt.sv
// Per-phase dwell down-counter: load wins over decrement, and the count
// saturates at zero.
module dwell_cnt #(
    parameter int CW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec_en,
    output logic          o_zero
);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec_en && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/phase_seq_ctrl.sv
// Phase sequencer: steps through NPH phases, each held DWELL+1 enabled cycles,
// with one-shot/repeat modes, EN freeze and ABORT; all outputs registered.
module phase_seq_ctrl
    import phase_seq_pkg::*;
#(
    parameter int  NPHASE_MAX = NPHASE_MAX_DEF,
    parameter int  CW         = CW_DEF,
    localparam int PW         = $clog2(NPHASE_MAX + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    phase_seq_ctrl_if.slave  bus
);
    state_e                r_state;
    logic [PW-1:0]         r_phase;
    logic [PW-1:0]         r_nph_l;
    logic [CW-1:0]         r_dwell_l;
    logic                  r_mode_l;
    logic [NPHASE_MAX-1:0] r_ph_oh;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic          w_zero;
    logic          w_legal;
    logic          w_start_ok;
    logic          w_step;
    logic          w_last;
    logic          w_finish;
    logic          w_load;
    logic          w_dec;
    logic [PW-1:0] w_next_ph;
    logic [CW-1:0] w_load_val;

    assign w_legal    = nph_legal(int'(bus.i_nph), NPHASE_MAX);
    assign w_start_ok = (r_state == S_IDLE) && bus.i_start && bus.i_en && !bus.i_abort && w_legal;
    // EN is a pure freeze: a HOLD->RUN cycle already counts as a dwell step.
    assign w_step     = ((r_state == S_RUN) || (r_state == S_HOLD)) && bus.i_en && !bus.i_abort;
    assign w_last     = (r_phase == r_nph_l - PW'(1));
    assign w_finish   = w_step && w_zero && w_last && !r_mode_l;
    assign w_next_ph  = w_last ? '0 : r_phase + PW'(1);
    assign w_load     = w_start_ok || (w_step && w_zero && !w_finish);
    assign w_load_val = w_start_ok ? bus.i_dwell : r_dwell_l;
    assign w_dec      = w_step && !w_zero;

    dwell_cnt #(.CW(CW)) u_dwell (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec_en   (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_nph_l   <= '0;
            r_dwell_l <= '0;
            r_mode_l  <= 1'b0;
            r_ph_oh   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (bus.i_abort) begin
                r_state <= S_IDLE;
                r_phase <= '0;
                r_ph_oh <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_ok) begin
                            r_state   <= S_RUN;
                            r_nph_l   <= bus.i_nph;
                            r_dwell_l <= bus.i_dwell;
                            r_mode_l  <= bus.i_mode;
                            r_phase   <= '0;
                            r_ph_oh   <= NPHASE_MAX'(1);
                            r_busy    <= 1'b1;
                        end else if (bus.i_start && bus.i_en && !w_legal) begin
                            r_err <= 1'b1;
                        end
                    end
                    S_RUN, S_HOLD: begin
                        if (!bus.i_en) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_state <= S_RUN;
                            if (w_finish) begin
                                r_state <= S_FINISH;
                                r_phase <= '0;
                                r_ph_oh <= '0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else if (w_zero) begin
                                r_phase <= w_next_ph;
                                r_ph_oh <= NPHASE_MAX'(1) << w_next_ph;
                            end
                        end
                    end
                    S_FINISH: r_state <= S_IDLE;
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.o_ph_oh  = r_ph_oh;
    assign bus.o_ph_idx = r_phase;
    assign bus.o_busy   = r_busy;
    assign bus.o_done   = r_done;
    assign bus.o_err    = r_err;
endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Bench for phase_seq_ctrl: elapsed-step reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_phase_seq_ctrl;
    localparam int NM = 6;
    localparam int CW = 4;
    localparam int PW = $clog2(NM + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   chk_on = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    phase_seq_ctrl_if #(.NPHASE_MAX(NM), .CW(CW), .PW(PW)) bus ();
    phase_seq_ctrl #(.NPHASE_MAX(NM), .CW(CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: a run is just a count t of enabled steps since START;
    // phase = t/(dwell+1), wrapping in repeat mode, ending in one-shot.
    bit m_busy, m_done, m_err, m_mode;
    int m_t, m_nph, m_dwell;

    function automatic int m_phase();
        return (m_t / (m_dwell + 1)) % m_nph;
    endfunction

    always @(posedge clk) begin
        bit was_done;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_t = 0;
        end else if (bus.i_abort) begin
            m_busy = 0; m_done = 0; m_err = 0; m_t = 0;
        end else if (m_busy) begin
            m_done = 0; m_err = 0;
            if (bus.i_en) begin
                m_t++;
                if (!m_mode && (m_t / (m_dwell + 1)) >= m_nph) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else begin
            was_done = m_done;
            m_done = 0; m_err = 0;
            if (!was_done && bus.i_start && bus.i_en) begin
                if (int'(bus.i_nph) >= 1 && int'(bus.i_nph) <= NM) begin
                    m_busy  = 1;
                    m_t     = 0;
                    m_nph   = int'(bus.i_nph);
                    m_dwell = int'(bus.i_dwell);
                    m_mode  = bus.i_mode;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            int e_oh, e_idx;
            bit e_busy, e_done, e_err;
            e_busy = rst_n && m_busy;
            e_done = rst_n && m_done;
            e_err  = rst_n && m_err;
            e_idx  = e_busy ? m_phase() : 0;
            e_oh   = e_busy ? (1 << e_idx) : 0;
            chk("ph_oh", int'(bus.o_ph_oh), e_oh);
            chk("ph_idx", int'(bus.o_ph_idx), e_idx);
            chk("busy", int'(bus.o_busy), int'(e_busy));
            chk("done", int'(bus.o_done), int'(e_done));
            chk("err", int'(bus.o_err), int'(e_err));
            chk("onehot_inv", int'($countones(bus.o_ph_oh) <= 1), 1);
            chk("oh_vs_idx", int'(bus.o_ph_oh), bus.o_busy ? (1 << bus.o_ph_idx) : 0);
            chk("done_busy_excl", int'(bus.o_done & bus.o_busy), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        bus.i_start = ($urandom_range(0, 99) < 20);
        bus.i_abort = ($urandom_range(0, 99) < 3);
        bus.i_en    = ($urandom_range(0, 99) < 85);
        bus.i_mode  = 1'($urandom_range(0, 1));
        bus.i_dwell = CW'($urandom_range(0, 3));
        bus.i_nph   = PW'($urandom_range(0, 7));
    endtask

    task automatic quiet();
        bus.i_start = 0; bus.i_abort = 0; bus.i_en = 1;
    endtask

    int exp_oh [11] = '{1, 1, 1, 2, 2, 2, 4, 4, 4, 0, 0};
    int exp_dn [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        int cyc;
        bus.i_en = 0; bus.i_start = 0; bus.i_abort = 0; bus.i_mode = 0;
        bus.i_dwell = '0; bus.i_nph = '0;
        #1 rst_n = 0;
        chk_on = 1;

        // reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            tick();
        end
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_oh", int'(bus.o_ph_oh), 0);
        quiet();
        tick();
        rst_n = 1;
        tick();
        chk("post_rst_busy", int'(bus.o_busy), 0);

        // one-shot NPH=3 DWELL=2; parameter changes mid-run must not matter
        bus.i_nph = 3; bus.i_dwell = 2; bus.i_mode = 0; bus.i_start = 1;
        tick();
        bus.i_start = 0; bus.i_nph = 5; bus.i_dwell = 7; bus.i_mode = 1;
        for (int k = 0; k < 11; k++) begin
            chk("oneshot_oh", int'(bus.o_ph_oh), exp_oh[k]);
            chk("oneshot_done", int'(bus.o_done), exp_dn[k]);
            tick();
        end

        // repeat NPH=2 DWELL=0, then abort
        bus.i_nph = 2; bus.i_dwell = 0; bus.i_mode = 1; bus.i_start = 1;
        tick();
        bus.i_start = 0;
        for (int k = 0; k < 5; k++) begin
            chk("repeat_oh", int'(bus.o_ph_oh), (k % 2 == 0) ? 1 : 2);
            chk("repeat_done", int'(bus.o_done), 0);
            tick();
        end
        bus.i_abort = 1;
        tick();
        bus.i_abort = 0;
        chk("abort_oh", int'(bus.o_ph_oh), 0);
        chk("abort_busy", int'(bus.o_busy), 0);
        chk("abort_done", int'(bus.o_done), 0);
        tick();

        // hold: EN low for 3 edges mid-dwell stretches 5 cycles to 8
        bus.i_nph = 1; bus.i_dwell = 4; bus.i_mode = 0; bus.i_start = 1;
        tick();
        bus.i_start = 0;
        cyc = 0;
        for (int c = 0; c < 30 && !bus.o_done; c++) begin
            if (bus.o_ph_oh[0]) cyc++;
            if (c == 1) bus.i_en = 0;
            if (c == 4) bus.i_en = 1;
            tick();
        end
        chk("hold_len", cyc, 8);
        chk("hold_done", int'(bus.o_done), 1);
        tick();

        // illegal NPH values
        bus.i_nph = 0; bus.i_start = 1;
        tick();
        bus.i_start = 0;
        chk("err_nph0", int'(bus.o_err), 1);
        chk("err_nph0_busy", int'(bus.o_busy), 0);
        tick();
        chk("err_pulse", int'(bus.o_err), 0);
        bus.i_nph = PW'(NM + 1); bus.i_start = 1;
        tick();
        bus.i_start = 0;
        chk("err_nphmax", int'(bus.o_err), 1);
        chk("err_nphmax_busy", int'(bus.o_busy), 0);
        tick();

        // START with ABORT in IDLE
        bus.i_nph = 2; bus.i_start = 1; bus.i_abort = 1;
        tick();
        quiet();
        chk("start_abort_busy", int'(bus.o_busy), 0);
        chk("start_abort_err", int'(bus.o_err), 0);
        tick();

        // START while busy is ignored: NPH=2 DWELL=1 stays 4 cycles
        bus.i_nph = 2; bus.i_dwell = 1; bus.i_mode = 0; bus.i_start = 1;
        tick();
        bus.i_start = 0;
        cyc = 0;
        for (int c = 0; c < 30 && !bus.o_done; c++) begin
            if (bus.o_busy) cyc++;
            if (c == 1) begin bus.i_start = 1; bus.i_nph = 5; bus.i_dwell = 3; end
            if (c == 2) bus.i_start = 0;
            tick();
        end
        chk("busy_start_len", cyc, 4);
        tick();

        // randomized traffic with occasional mid-run reset
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 0;
                @(posedge clk);
                #1 rst_n = 1;
            end else begin
                tick();
            end
        end

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
